uart_echo: RTL and testbench

Parametrised UART echo core for the SharkBoad Spartan-3E top level. It contains:
- a single oversampling baud-tick generator;
- a 16x-oversampled receiver;
- a power-of-two receive FIFO;
- a transmitter that echoes every correctly received word back out.

It replaces the loopback built from two free-running tick counters and a fixed 8-bit UART. The tick generator, data width, FIFO depth and flow control are all parametrised, and framing errors and overruns are reported.

---
 rtl/uart_echo_if.sv | 33 +++
 rtl/uart_echo.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_uart_echo.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_echo_if.sv
// uart_echo_if: serial pins and status outputs of the uart_echo core.
//   rx_in, tx_hold            -> core (serial input, TX flow control)
//   tx_out, tx_busy           <- core (serial output, frame-in-progress flag)
//   rx_data, rx_strobe        <- core (last accepted word, one-cycle update pulse)
//   frame_err, parity_err,
//   overrun                   <- core (one-cycle error pulses)
//   fifo_level                <- core (receive FIFO occupancy)
// The slave modport is the core side; master is the surrounding logic or bench.
interface uart_echo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                         rx_in;
  logic                         tx_hold;
  logic                         tx_out;
  logic                         tx_busy;
  logic [DATA_BITS-1:0]         rx_data;
  logic                         rx_strobe;
  logic                         frame_err;
  logic                         parity_err;
  logic                         overrun;
  logic [$clog2(FIFO_DEPTH):0]  fifo_level;

  modport master (
    output rx_in, tx_hold,
    input  tx_out, tx_busy, rx_data, rx_strobe, frame_err, parity_err, overrun, fifo_level
  );

  modport slave (
    input  rx_in, tx_hold,
    output tx_out, tx_busy, rx_data, rx_strobe, frame_err, parity_err, overrun, fifo_level
  );
endinterface

// File: rtl/uart_echo.sv
// uart_echo: UART echo core. A shared 16x oversampling tick drives a receiver
// that pushes good words into a power-of-two FIFO, and a transmitter that
// sends the FIFO contents back out.
// Ports: clk (single clock), reset (async, active high), bus (uart_echo_if.slave).
// Optional feature: define UART_ECHO_PARITY_EN for an even-parity bit in both
// directions; without it no parity bit is sent or expected and parity_err is 0.
module uart_echo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic        clk,
  input logic        reset,
  uart_echo_if.slave bus
);
  localparam int OS_DIV = CLK_FREQ / (16 * BAUD);
  localparam int CNT_W  = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_ECHO_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  // Oversampling tick: one pulse every OS_DIV clocks.
  logic [CNT_W-1:0] osCnt_q;
  logic             osTick;
  assign osTick = (osCnt_q == CNT_W'(OS_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       osCnt_q <= '0;
    else if (osTick) osCnt_q <= '0;
    else             osCnt_q <= osCnt_q + 1'b1;
  end

  // Two-flop synchroniser; resets to the idle line level so reset never looks like a start bit.
  logic [1:0] rxSync_q;
  logic       rxBit;
  assign rxBit = rxSync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rxSync_q <= 2'b11;
    else       rxSync_q <= {rxSync_q[0], bus.rx_in};
  end

  // Receive FIFO. The push is the registered strobe, so it lands in the same
  // cycle rx_strobe is visible; full was already checked when the word was accepted.
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wrPtr_q, rdPtr_q;
  logic [LVL_W-1:0]     level_q;
  logic                 fifoFull, fifoEmpty, push, pop;
  logic                 rxStrobe_q;
  logic [DATA_BITS-1:0] rxData_q;

  assign fifoFull  = (level_q == LVL_W'(FIFO_DEPTH));
  assign fifoEmpty = (level_q == '0);
  assign push      = rxStrobe_q && !fifoFull;

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= rxData_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Receiver. The 4-bit tick counter wraps on its own, so a full bit is 16 ticks;
  // only the start bit is cut to 8 ticks to move the sample point to mid-bit.
  logic [2:0]           rxState_q, rxState_d;
  logic [3:0]           rxCnt_q, rxCnt_d, rxBitIdx_q, rxBitIdx_d;
  logic [DATA_BITS-1:0] rxShift_q, rxShift_d, rxData_d;
  logic                 rxStrobe_d, frameErr_q, frameErr_d, overrun_q, overrun_d;
`ifdef UART_ECHO_PARITY_EN
  logic                 rxPar_q, rxPar_d, parityErr_q, parityErr_d;
`endif

  always_comb begin
    rxState_d  = rxState_q;
    rxCnt_d    = rxCnt_q;
    rxBitIdx_d = rxBitIdx_q;
    rxShift_d  = rxShift_q;
    rxData_d   = rxData_q;
    rxStrobe_d = 1'b0;
    frameErr_d = 1'b0;
    overrun_d  = 1'b0;
`ifdef UART_ECHO_PARITY_EN
    rxPar_d     = rxPar_q;
    parityErr_d = 1'b0;
`endif
    if (osTick) begin
      rxCnt_d = rxCnt_q + 4'd1;
      case (rxState_q)
        S_IDLE: begin
          rxCnt_d = '0;
          if (!rxBit) rxState_d = S_START;
        end
        S_START: if (rxCnt_q == 4'd7) begin
          rxCnt_d    = '0;
          rxBitIdx_d = '0;
          rxState_d  = rxBit ? S_IDLE : S_DATA;
        end
        S_DATA: if (rxCnt_q == 4'd15) begin
          rxShift_d  = {rxBit, rxShift_q[DATA_BITS-1:1]};
          rxBitIdx_d = rxBitIdx_q + 4'd1;
`ifdef UART_ECHO_PARITY_EN
          if (rxBitIdx_q == LAST_BIT) rxState_d = S_PARITY;
`else
          if (rxBitIdx_q == LAST_BIT) rxState_d = S_STOP;
`endif
        end
`ifdef UART_ECHO_PARITY_EN
        S_PARITY: if (rxCnt_q == 4'd15) begin
          rxPar_d   = rxBit;
          rxState_d = S_STOP;
        end
`endif
        S_STOP: if (rxCnt_q == 4'd15) begin
          rxState_d = S_IDLE;
          // Framing beats parity, parity beats overrun.
          if (!rxBit) frameErr_d = 1'b1;
`ifdef UART_ECHO_PARITY_EN
          else if ((^rxShift_q) != rxPar_q) parityErr_d = 1'b1;
`endif
          else if (fifoFull) overrun_d = 1'b1;
          else begin
            rxStrobe_d = 1'b1;
            rxData_d   = rxShift_q;
          end
        end
        default: rxState_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxState_q  <= S_IDLE;
      rxCnt_q    <= '0;
      rxBitIdx_q <= '0;
      rxShift_q  <= '0;
      rxData_q   <= '0;
      rxStrobe_q <= 1'b0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rxState_q  <= rxState_d;
      rxCnt_q    <= rxCnt_d;
      rxBitIdx_q <= rxBitIdx_d;
      rxShift_q  <= rxShift_d;
      rxData_q   <= rxData_d;
      rxStrobe_q <= rxStrobe_d;
      frameErr_q <= frameErr_d;
      overrun_q  <= overrun_d;
    end
  end

`ifdef UART_ECHO_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxPar_q     <= 1'b0;
      parityErr_q <= 1'b0;
    end else begin
      rxPar_q     <= rxPar_d;
      parityErr_q <= parityErr_d;
    end
  end
`endif

  // Transmitter. Popping the head and dropping the line happen on the same tick,
  // and each later bit boundary is the 16th tick after the previous one.
  logic [2:0]           txState_q, txState_d;
  logic [3:0]           txCnt_q, txCnt_d, txBitIdx_q, txBitIdx_d;
  logic [DATA_BITS-1:0] txShift_q, txShift_d;
  logic                 txOut_q, txOut_d, txBusy_q, txBusy_d;
`ifdef UART_ECHO_PARITY_EN
  logic                 txPar_q, txPar_d;
`endif

  always_comb begin
    txState_d  = txState_q;
    txCnt_d    = txCnt_q;
    txBitIdx_d = txBitIdx_q;
    txShift_d  = txShift_q;
    txOut_d    = txOut_q;
    txBusy_d   = txBusy_q;
    pop        = 1'b0;
`ifdef UART_ECHO_PARITY_EN
    txPar_d    = txPar_q;
`endif
    if (osTick) begin
      txCnt_d = txCnt_q + 4'd1;
      case (txState_q)
        S_IDLE: begin
          txCnt_d = '0;
          if (!fifoEmpty && !bus.tx_hold) begin
            pop       = 1'b1;
            txShift_d = mem_q[rdPtr_q];
            txOut_d   = 1'b0;
            txBusy_d  = 1'b1;
            txState_d = S_START;
`ifdef UART_ECHO_PARITY_EN
            txPar_d   = ^mem_q[rdPtr_q];
`endif
          end
        end
        S_START: if (txCnt_q == 4'd15) begin
          txBitIdx_d = '0;
          txOut_d    = txShift_q[0];
          txShift_d  = txShift_q >> 1;
          txState_d  = S_DATA;
        end
        S_DATA: if (txCnt_q == 4'd15) begin
          if (txBitIdx_q == LAST_BIT) begin
`ifdef UART_ECHO_PARITY_EN
            txOut_d   = txPar_q;
            txState_d = S_PARITY;
`else
            txOut_d   = 1'b1;
            txState_d = S_STOP;
`endif
          end else begin
            txBitIdx_d = txBitIdx_q + 4'd1;
            txOut_d    = txShift_q[0];
            txShift_d  = txShift_q >> 1;
          end
        end
`ifdef UART_ECHO_PARITY_EN
        S_PARITY: if (txCnt_q == 4'd15) begin
          txOut_d   = 1'b1;
          txState_d = S_STOP;
        end
`endif
        S_STOP: if (txCnt_q == 4'd15) begin
          txBusy_d  = 1'b0;
          txState_d = S_IDLE;
        end
        default: txState_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txState_q  <= S_IDLE;
      txCnt_q    <= '0;
      txBitIdx_q <= '0;
      txShift_q  <= '0;
      txOut_q    <= 1'b1;
      txBusy_q   <= 1'b0;
    end else begin
      txState_q  <= txState_d;
      txCnt_q    <= txCnt_d;
      txBitIdx_q <= txBitIdx_d;
      txShift_q  <= txShift_d;
      txOut_q    <= txOut_d;
      txBusy_q   <= txBusy_d;
    end
  end

`ifdef UART_ECHO_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) txPar_q <= 1'b0;
    else       txPar_q <= txPar_d;
  end
  assign bus.parity_err = parityErr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.tx_out     = txOut_q;
  assign bus.tx_busy    = txBusy_q;
  assign bus.rx_data    = rxData_q;
  assign bus.rx_strobe  = rxStrobe_q;
  assign bus.frame_err  = frameErr_q;
  assign bus.overrun    = overrun_q;
  assign bus.fifo_level = level_q;
endmodule

// File: tb/tb_uart_echo.sv
// tb_uart_echo: directed bench for uart_echo with OS_DIV=10 (160 clk per bit).
// Pulse/busy monitors and a TX frame decoder run beside one linear stimulus block.
module tb_uart_echo;
  localparam int CLK_FREQ   = 1600000;
  localparam int BAUD       = 10000;
  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int BIT_CLK    = 160;

  logic clk = 1'b0;
  logic reset;

  uart_echo_if #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  uart_echo #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int        strobeCount = 0;
  int        frameErrCount = 0;
  int        overrunCount = 0;
  int        parityErrCount = 0;
  logic [7:0] lastRxData = 8'h00;
  int        busyRun = 0;
  int        lastBusyLen = 0;

  logic [9:0] txQ [$];
  logic [9:0] txBits = '0;
  int         txCnt = 0;
  bit         txActive = 1'b0;

  // Counts output pulses and measures how long each tx_busy period lasts.
  always @(negedge clk) begin
    if (bus.rx_strobe === 1'b1) begin
      strobeCount++;
      lastRxData = bus.rx_data;
    end
    if (bus.frame_err === 1'b1)  frameErrCount++;
    if (bus.overrun === 1'b1)    overrunCount++;
    if (bus.parity_err === 1'b1) parityErrCount++;
    if (bus.tx_busy === 1'b1) busyRun++;
    else if (busyRun != 0) begin
      lastBusyLen = busyRun;
      busyRun = 0;
    end
  end

  // Decodes tx_out frames by sampling mid-bit at 160 clk spacing; bit 0 of the
  // stored frame is the start bit, bit 9 the stop bit.
  always @(negedge clk) begin
    if (reset) begin
      txActive = 1'b0;
      txCnt = 0;
    end else if (!txActive) begin
      if (bus.tx_out === 1'b0) begin
        txActive = 1'b1;
        txCnt = 0;
      end
    end else begin
      txCnt++;
      if (txCnt % BIT_CLK == BIT_CLK / 2) txBits[txCnt / BIT_CLK] = bus.tx_out;
      if (txCnt == 9 * BIT_CLK + BIT_CLK / 2) begin
        txQ.push_back(txBits);
        txActive = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one 8N1 frame on rx_in; stopBit=0 produces a framing error.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
    bus.rx_in = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx_in = data[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    bus.rx_in = stopBit;
    repeat (BIT_CLK) @(negedge clk);
    bus.rx_in = 1'b1;
  endtask

  task automatic waitFrames(input int n, input int budget);
    for (int i = 0; i < budget && txQ.size() < n; i++) @(negedge clk);
  endtask

  task automatic checkFrame(input string tag, input logic [7:0] data);
    logic [9:0] frame;
    frame = 'x;
    if (txQ.size() > 0) frame = txQ.pop_front();
    checkOutput(tag, 32'(frame), 32'({1'b1, data, 1'b0}));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".tx_out"},     32'(bus.tx_out), 32'd1);
    checkOutput({tag, ".tx_busy"},    32'(bus.tx_busy), 32'd0);
    checkOutput({tag, ".rx_data"},    32'(bus.rx_data), 32'd0);
    checkOutput({tag, ".rx_strobe"},  32'(bus.rx_strobe), 32'd0);
    checkOutput({tag, ".frame_err"},  32'(bus.frame_err), 32'd0);
    checkOutput({tag, ".parity_err"}, 32'(bus.parity_err), 32'd0);
    checkOutput({tag, ".overrun"},    32'(bus.overrun), 32'd0);
    checkOutput({tag, ".fifo_level"}, 32'(bus.fifo_level), 32'd0);
  endtask

  int baseStrobe, baseFrame, baseOverrun;

  initial begin
    reset = 1'b0;
    bus.rx_in = 1'b1;
    bus.tx_hold = 1'b0;
    #2 reset = 1'b1;
    repeat (5) @(negedge clk);
    checkResetValues("reset");

    // Idle line after reset release.
    reset = 1'b0;
    repeat (5000) @(negedge clk);
    checkOutput("idle.tx_out", 32'(bus.tx_out), 32'd1);
    checkOutput("idle.tx_busy", 32'(bus.tx_busy), 32'd0);
    checkOutput("idle.fifo_level", 32'(bus.fifo_level), 32'd0);
    checkOutput("idle.pulses", 32'(strobeCount + frameErrCount + overrunCount + parityErrCount), 32'd0);

    // 0xA5 echo.
    applyStimulus(8'hA5, 1'b1);
    waitFrames(1, 3000);
    checkOutput("a5.strobes", 32'(strobeCount), 32'd1);
    checkOutput("a5.rx_data", 32'(lastRxData), 32'hA5);
    checkFrame("a5.tx_frame", 8'hA5);
    repeat (200) @(negedge clk);
    checkOutput("a5.busy_len", 32'(lastBusyLen), 32'd1600);
    checkOutput("a5.fifo_level", 32'(bus.fifo_level), 32'd0);

    // 40-clk glitch is rejected.
    bus.rx_in = 1'b0;
    repeat (40) @(negedge clk);
    bus.rx_in = 1'b1;
    repeat (2000) @(negedge clk);
    checkOutput("glitch.strobes", 32'(strobeCount), 32'd1);
    checkOutput("glitch.frame_err", 32'(frameErrCount), 32'd0);
    checkOutput("glitch.tx_frames", 32'(txQ.size()), 32'd0);

    // Framing error on 0x3C.
    applyStimulus(8'h3C, 1'b0);
    repeat (2000) @(negedge clk);
    checkOutput("ferr.frame_err", 32'(frameErrCount), 32'd1);
    checkOutput("ferr.strobes", 32'(strobeCount), 32'd1);
    checkOutput("ferr.fifo_level", 32'(bus.fifo_level), 32'd0);
    checkOutput("ferr.tx_out", 32'(bus.tx_out), 32'd1);
    checkOutput("ferr.tx_frames", 32'(txQ.size()), 32'd0);

    // Held TX: four words fill the FIFO, the fifth overruns.
    baseStrobe = strobeCount;
    baseOverrun = overrunCount;
    bus.tx_hold = 1'b1;
    for (int b = 1; b <= 5; b++) applyStimulus(8'(b), 1'b1);
    repeat (300) @(negedge clk);
    checkOutput("hold.strobes", 32'(strobeCount - baseStrobe), 32'd4);
    checkOutput("hold.fifo_level", 32'(bus.fifo_level), 32'd4);
    checkOutput("hold.overrun", 32'(overrunCount - baseOverrun), 32'd1);
    checkOutput("hold.rx_data", 32'(lastRxData), 32'h04);
    checkOutput("hold.tx_frames", 32'(txQ.size()), 32'd0);
    checkOutput("hold.tx_out", 32'(bus.tx_out), 32'd1);
    bus.tx_hold = 1'b0;
    waitFrames(4, 8000);
    checkOutput("drain.count", 32'(txQ.size()), 32'd4);
    for (int b = 1; b <= 4; b++) checkFrame("drain.tx_frame", 8'(b));
    repeat (200) @(negedge clk);
    checkOutput("drain.fifo_level", 32'(bus.fifo_level), 32'd0);

    // Reset in the middle of TX data bit 3 (0x33 -> bit 3 is 0).
    baseFrame = frameErrCount;
    applyStimulus(8'h33, 1'b1);
    for (int i = 0; i < 3000 && busyRun != 720; i++) @(negedge clk);
    checkOutput("midtx.busy_run", 32'(busyRun), 32'd720);
    checkOutput("midtx.bit3", 32'(bus.tx_out), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("midtx.async_tx_out", 32'(bus.tx_out), 32'd1);
    checkResetValues("midtx");
    repeat (20) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("midtx.no_stray_frame", 32'(txQ.size()), 32'd0);

    // Echo after reset.
    baseStrobe = strobeCount;
    applyStimulus(8'h5A, 1'b1);
    waitFrames(1, 3000);
    checkOutput("5a.strobes", 32'(strobeCount - baseStrobe), 32'd1);
    checkOutput("5a.rx_data", 32'(lastRxData), 32'h5A);
    checkFrame("5a.tx_frame", 8'h5A);
    repeat (200) @(negedge clk);
    checkOutput("5a.busy_len", 32'(lastBusyLen), 32'd1600);
    checkOutput("5a.frame_err", 32'(frameErrCount - baseFrame), 32'd0);
    checkOutput("end.parity_err", 32'(parityErrCount), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
